// File: rtl/floo_pkg.sv
// Shared types and helpers for the multi-channel VC credit egress stage.
package floo_pkg;

  typedef enum logic {
    IdleLock = 1'b0,
    Locked   = 1'b1
  } lock_e;

  // Credits a VC starts with after reset; the wormhole VC has its own depth.
  function automatic int unsigned vc_init_depth(input int unsigned vc,
                                                input int unsigned wh_id,
                                                input int unsigned depth,
                                                input int unsigned wh_depth);
    return (vc == wh_id) ? wh_depth : depth;
  endfunction

endpackage

// File: rtl/floo_vc_credit_chan.sv
// One physical channel: per-VC credit counters, wormhole lock and link register.
module floo_vc_credit_chan
  import floo_pkg::*;
#(
  parameter int unsigned NumVC           = 4,
  parameter int unsigned VCIdWidth       = 2,
  parameter int unsigned VCDepth         = 2,
  parameter int unsigned WormholeVCId    = 0,
  parameter int unsigned WormholeVCDepth = 3,
  parameter int unsigned CntWidth        = 2,
  parameter int unsigned FlitWidth       = 64,
  parameter bit          CreditShortcut  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [VCIdWidth-1:0] vc_id_i,
  input  logic                 last_i,
  input  logic [FlitWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [VCIdWidth-1:0] vc_id_o,
  output logic [FlitWidth-1:0] data_o,
  input  logic                 credit_v_i,
  input  logic [VCIdWidth-1:0] credit_id_i,
  output logic [NumVC-1:0]     credit_avail_o,
  output logic                 overflow_o
);

  logic [NumVC-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [NumVC-1:0]               ovf_hit;
  logic                           overflow_q, overflow_d;
  lock_e                          lock_q, lock_d;
  logic [VCIdWidth-1:0]           lock_vc_q, lock_vc_d;
  logic                           valid_q;
  logic [VCIdWidth-1:0]           vc_q;
  logic [FlitWidth-1:0]           data_q;
  logic                           vc_ok, has_cnt, shortcut, lock_ok, acc;

  assign vc_ok    = 32'(vc_id_i) < NumVC;
  assign shortcut = CreditShortcut && credit_v_i && (credit_id_i == vc_id_i);
  assign lock_ok  = (lock_q == IdleLock) || (vc_id_i == lock_vc_q);

  // Looped select keeps an out-of-range VC id from indexing past the array.
  always_comb begin
    has_cnt = 1'b0;
    for (int v = 0; v < NumVC; v++)
      if (vc_id_i == VCIdWidth'(v) && cnt_q[v] != '0) has_cnt = 1'b1;
  end

  assign acc     = valid_i && vc_ok && (has_cnt || shortcut) && lock_ok;
  assign ready_o = acc;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_hit = '0;
    for (int v = 0; v < NumVC; v++) begin
      if (acc && vc_id_i == VCIdWidth'(v) &&
          !(credit_v_i && credit_id_i == VCIdWidth'(v))) begin
        cnt_d[v] = cnt_q[v] - CntWidth'(1);
      end else if (credit_v_i && credit_id_i == VCIdWidth'(v) &&
                   !(acc && vc_id_i == VCIdWidth'(v))) begin
        // A credit beyond the reset depth is a downstream bug: saturate and flag.
        if (cnt_q[v] == CntWidth'(vc_init_depth(v, WormholeVCId, VCDepth, WormholeVCDepth)))
          ovf_hit[v] = 1'b1;
        else
          cnt_d[v] = cnt_q[v] + CntWidth'(1);
      end
    end
  end

  assign overflow_d = overflow_q | (|ovf_hit);

  always_comb begin
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    case (lock_q)
      IdleLock: if (acc && !last_i) begin
        lock_d    = Locked;
        lock_vc_d = vc_id_i;
      end
      Locked:   if (acc && last_i) lock_d = IdleLock;
      default:  lock_d = IdleLock;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int v = 0; v < NumVC; v++)
        cnt_q[v] <= CntWidth'(vc_init_depth(v, WormholeVCId, VCDepth, WormholeVCDepth));
      overflow_q <= 1'b0;
      lock_q     <= IdleLock;
      lock_vc_q  <= '0;
      valid_q    <= 1'b0;
      vc_q       <= '0;
      data_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      lock_q     <= lock_d;
      lock_vc_q  <= lock_vc_d;
      valid_q    <= acc;
      if (acc) begin
        vc_q   <= vc_id_i;
        data_q <= data_i;
      end
    end
  end

  for (genvar v = 0; v < NumVC; v++) begin : g_avail
    assign credit_avail_o[v] = cnt_q[v] != '0;
  end

  assign valid_o    = valid_q;
  assign vc_id_o    = vc_q;
  assign data_o     = data_q;
  assign overflow_o = overflow_q;

  a_vc_in_range: assert property (@(posedge clk_i) disable iff (rst_i) valid_i |-> vc_ok);

endmodule

// File: rtl/floo_vc_multi_credit_egress.sv
// Credit-based VC egress replicated over NumChannels independent physical links.
module floo_vc_multi_credit_egress
  import floo_pkg::*;
#(
  parameter int unsigned NumChannels     = 3,
  parameter int unsigned NumVC           = 4,
  parameter int unsigned VCIdWidth       = (NumVC > 1) ? $clog2(NumVC) : 1,
  parameter int unsigned VCDepth         = 2,
  parameter int unsigned WormholeVCId    = 0,
  parameter int unsigned WormholeVCDepth = 3,
  parameter int unsigned CntWidth        =
    $clog2(((VCDepth > WormholeVCDepth) ? VCDepth : WormholeVCDepth) + 1),
  parameter int unsigned FlitWidth       = 64,
  parameter bit          CreditShortcut  = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           valid_i,
  output logic [NumChannels-1:0]           ready_o,
  input  logic [NumChannels*VCIdWidth-1:0] vc_id_i,
  input  logic [NumChannels-1:0]           last_i,
  input  logic [NumChannels*FlitWidth-1:0] data_i,
  output logic [NumChannels-1:0]           valid_o,
  output logic [NumChannels*VCIdWidth-1:0] vc_id_o,
  output logic [NumChannels*FlitWidth-1:0] data_o,
  input  logic [NumChannels-1:0]           credit_v_i,
  input  logic [NumChannels*VCIdWidth-1:0] credit_id_i,
  output logic [NumChannels*NumVC-1:0]     credit_avail_o,
  output logic [NumChannels-1:0]           overflow_o
);

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    floo_vc_credit_chan #(
      .NumVC          (NumVC),
      .VCIdWidth      (VCIdWidth),
      .VCDepth        (VCDepth),
      .WormholeVCId   (WormholeVCId),
      .WormholeVCDepth(WormholeVCDepth),
      .CntWidth       (CntWidth),
      .FlitWidth      (FlitWidth),
      .CreditShortcut (CreditShortcut)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .valid_i       (valid_i[c]),
      .ready_o       (ready_o[c]),
      .vc_id_i       (vc_id_i[c*VCIdWidth +: VCIdWidth]),
      .last_i        (last_i[c]),
      .data_i        (data_i[c*FlitWidth +: FlitWidth]),
      .valid_o       (valid_o[c]),
      .vc_id_o       (vc_id_o[c*VCIdWidth +: VCIdWidth]),
      .data_o        (data_o[c*FlitWidth +: FlitWidth]),
      .credit_v_i    (credit_v_i[c]),
      .credit_id_i   (credit_id_i[c*VCIdWidth +: VCIdWidth]),
      .credit_avail_o(credit_avail_o[c*NumVC +: NumVC]),
      .overflow_o    (overflow_o[c])
    );
  end

endmodule
